// File: rtl/dma_pkg.sv
// Shared types and status codes for the word-copy DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Only the two byte-offset bits decide whether an address is word aligned.
  function automatic logic word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/naive_bus_if.sv
// Simple request/grant bus: separate read and write channels, fixed read latency.
interface naive_bus;

  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/bus_dma_copier.sv
// Word-by-word memory copier: read one word, write it back out, repeat,
// with alignment checking and a per-request grant timeout.
module bus_dma_copier
  import dma_pkg::*;
#(
  parameter int GNT_TIMEOUT = 255,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  naive_bus.master    bus
);

  localparam logic [15:0] TMO_LAST = 16'(GNT_TIMEOUT - 1);
  localparam logic [2:0]  LAT_LAST = 3'(RD_LATENCY - 1);

  state_t      state_reg;
  logic [31:0] src_reg;
  logic [31:0] dst_reg;
  logic [31:0] hold_reg;
  logic [15:0] count_reg;
  logic [15:0] tmo_reg;
  logic [2:0]  lat_reg;
  logic        rd_req_reg;
  logic [31:0] rd_addr_reg;
  logic        wr_req_reg;
  logic [31:0] wr_addr_reg;
  logic        tmo_hit;

  // The request drops one cycle after the counter reaches GNT_TIMEOUT, so
  // the decision is taken while the counter still holds GNT_TIMEOUT-1.
  assign tmo_hit = (tmo_reg == TMO_LAST);

  assign bus.rd_req  = rd_req_reg;
  assign bus.rd_addr = rd_addr_reg;
  assign bus.wr_req  = wr_req_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_req_reg ? hold_reg : 32'd0;
  assign bus.wr_be   = {4{wr_req_reg}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      hold_reg    <= '0;
      count_reg   <= '0;
      tmo_reg     <= '0;
      lat_reg     <= '0;
      rd_req_reg  <= 1'b0;
      rd_addr_reg <= '0;
      wr_req_reg  <= 1'b0;
      wr_addr_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_OK;
    end else begin
      done <= 1'b0;
      err  <= ERR_OK;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg   <= src_addr;
            dst_reg   <= dst_addr;
            count_reg <= len_words;
            tmo_reg   <= '0;
            busy      <= 1'b1;
            if (!word_aligned(src_addr[1:0]) || !word_aligned(dst_addr[1:0])) begin
              state_reg <= FINISH;
              done      <= 1'b1;
              err       <= ERR_ALIGN;
            end else if (len_words == 16'd0) begin
              state_reg <= FINISH;
              done      <= 1'b1;
            end else begin
              state_reg   <= RD_REQ;
              rd_req_reg  <= 1'b1;
              rd_addr_reg <= src_addr;
            end
          end
        end

        RD_REQ: begin
          if (bus.rd_gnt) begin
            rd_req_reg  <= 1'b0;
            rd_addr_reg <= '0;
            tmo_reg     <= '0;
            lat_reg     <= '0;
            state_reg   <= RD_WAIT;
          end else begin
            tmo_reg <= tmo_reg + 16'd1;
            if (tmo_hit) begin
              rd_req_reg  <= 1'b0;
              rd_addr_reg <= '0;
              state_reg   <= FINISH;
              done        <= 1'b1;
              err         <= ERR_TIMEOUT;
            end
          end
        end

        RD_WAIT: begin
          if (lat_reg == LAT_LAST) begin
            hold_reg    <= bus.rd_data;
            wr_req_reg  <= 1'b1;
            wr_addr_reg <= dst_reg;
            state_reg   <= WR_REQ;
          end else begin
            lat_reg <= lat_reg + 3'd1;
          end
        end

        WR_REQ: begin
          if (bus.wr_gnt) begin
            wr_req_reg  <= 1'b0;
            wr_addr_reg <= '0;
            tmo_reg     <= '0;
            src_reg     <= src_reg + 32'd4;
            dst_reg     <= dst_reg + 32'd4;
            count_reg   <= count_reg - 16'd1;
            if (count_reg == 16'd1) begin
              state_reg <= FINISH;
              done      <= 1'b1;
            end else begin
              state_reg   <= RD_REQ;
              rd_req_reg  <= 1'b1;
              rd_addr_reg <= src_reg + 32'd4;
            end
          end else begin
            tmo_reg <= tmo_reg + 16'd1;
            if (tmo_hit) begin
              wr_req_reg  <= 1'b0;
              wr_addr_reg <= '0;
              state_reg   <= FINISH;
              done        <= 1'b1;
              err         <= ERR_TIMEOUT;
            end
          end
        end

        FINISH: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_copier.sv
// Randomized scoreboard bench for bus_dma_copier against a 4 kB RAM slave.
module tb_bus_dma_copier;

  localparam int TMO = 8;
  localparam int RDL = 1;
  localparam int NO_STOP = 1 << 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  naive_bus bus_if ();

  bus_dma_copier #(.GNT_TIMEOUT(TMO), .RD_LATENCY(RDL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- RAM slave with programmable grant stalls ----------------
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        ram_init;
  int          rd_stall = 0;
  int          wr_stall = 0;
  int          rd_wait = 0;
  int          wr_wait = 0;
  logic [31:0] rd_data_r = '0;

  function automatic logic [31:0] init_word(input int i);
    if (i >= 64 && i <= 67) return 32'h1111_1111 * 32'(i - 63);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  assign bus_if.rd_gnt  = bus_if.rd_req && (rd_wait >= rd_stall);
  assign bus_if.wr_gnt  = bus_if.wr_req && (wr_wait >= wr_stall);
  assign bus_if.rd_data = rd_data_r;

  always @(posedge clk) begin
    rd_wait <= (bus_if.rd_req && !bus_if.rd_gnt) ? rd_wait + 1 : 0;
    wr_wait <= (bus_if.wr_req && !bus_if.wr_gnt) ? wr_wait + 1 : 0;
    if (bus_if.rd_gnt) rd_data_r <= mem[bus_if.rd_addr[11:2]];
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (bus_if.wr_req && bus_if.wr_gnt) begin
      mem[bus_if.wr_addr[11:2]] <= bus_if.wr_data;
    end
  end

  // ---------------- reference model and scoreboard queues ----------------
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [1:0] err; int cycles; int start_cyc; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];

  // Behavioural copy: done latency is counted inclusively from the start
  // cycle, each word costing read + latency + write plus any grant stalls.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int stop, input int scyc);
    done_t de;
    wr_t we;
    logic [31:0] a, b;
    de.start_cyc = scyc;
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
      de.err = 2'd1; de.cycles = 2; done_q.push_back(de);
    end else if (n == 0) begin
      de.err = 2'd0; de.cycles = 2; done_q.push_back(de);
    end else if (rd_stall >= TMO) begin
      de.err = 2'd2; de.cycles = TMO + 2; done_q.push_back(de);
    end else begin
      for (int i = 0; i < n && i < stop; i++) begin
        a = s + 32'(4 * i);
        b = d + 32'(4 * i);
        ref_mem[b[11:2]] = ref_mem[a[11:2]];
        we.addr = b;
        we.data = ref_mem[b[11:2]];
        wr_q.push_back(we);
      end
      if (stop >= n) begin
        de.err = 2'd0; de.cycles = n * (2 + RDL + rd_stall + wr_stall) + 2;
        done_q.push_back(de);
      end
    end
  endtask

  // ---------------- monitor ----------------
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  logic prev_rd_req = 1'b0, prev_rd_gnt = 1'b0, prev_wr_req = 1'b0, prev_wr_gnt = 1'b0;
  logic [31:0] prev_rd_addr = '0, prev_wr_addr = '0, prev_wr_data = '0;

  initial begin
    wr_t   we;
    done_t de;
    forever begin
      @(negedge clk);
      if (bus_if.rd_req) rd_cycles++;
      if (bus_if.wr_req) wr_cycles++;
      if (!rst) begin
        chk("req_exclusive", 32'(bus_if.rd_req & bus_if.wr_req), 32'd0);
        if (!bus_if.rd_req) chk("rd_idle_zero", bus_if.rd_addr, 32'd0);
        if (!bus_if.wr_req)
          chk("wr_idle_zero", bus_if.wr_addr | bus_if.wr_data | 32'(bus_if.wr_be), 32'd0);
        if (prev_rd_req && !prev_rd_gnt && bus_if.rd_req)
          chk("rd_addr_stable", bus_if.rd_addr, prev_rd_addr);
        if (prev_wr_req && !prev_wr_gnt && bus_if.wr_req) begin
          chk("wr_addr_stable", bus_if.wr_addr, prev_wr_addr);
          chk("wr_data_stable", bus_if.wr_data, prev_wr_data);
        end
        if (bus_if.wr_req && bus_if.wr_gnt) begin
          $display("write addr=%h data=%h be=%h", bus_if.wr_addr, bus_if.wr_data, bus_if.wr_be);
          if (wr_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_write: got addr %h, expected no write", bus_if.wr_addr);
          end else begin
            we = wr_q.pop_front();
            chk("wr_addr", bus_if.wr_addr, we.addr);
            chk("wr_data", bus_if.wr_data, we.data);
            chk("wr_be", 32'(bus_if.wr_be), 32'hF);
          end
        end
        if (done) begin
          $display("done err=%0d at cycle %0d", err, cyc);
          if (done_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: got done err=%0d, expected none", err);
          end else begin
            de = done_q.pop_front();
            chk("done_err", 32'(err), 32'(de.err));
            chk("done_cycles", 32'(cyc - de.start_cyc + 1), 32'(de.cycles));
          end
        end
      end
      prev_rd_req  = bus_if.rd_req;  prev_rd_gnt = bus_if.rd_gnt;  prev_rd_addr = bus_if.rd_addr;
      prev_wr_req  = bus_if.wr_req;  prev_wr_gnt = bus_if.wr_gnt;
      prev_wr_addr = bus_if.wr_addr; prev_wr_data = bus_if.wr_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n, input int stop);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len_words = 16'(n); start = 1'b1;
    $display("start src=%h dst=%h len=%0d rd_stall=%0d wr_stall=%0d", s, d, n, rd_stall, wr_stall);
    model_copy(s, d, n, stop, cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout_%s: got no done in 400 cycles, expected a done pulse", tag);
    end
  endtask

  initial begin
    int r0, w0, nw;
    logic [31:0] s, d;
    rst = 1'b1; ram_init = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; len_words = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1 ram_init = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, done, err, bus_if.rd_req, bus_if.wr_req}, 32'd0);
    chk("reset_bus", bus_if.rd_addr | bus_if.wr_addr | bus_if.wr_data | 32'(bus_if.wr_be), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic four-word copy from the preloaded pattern.
    launch(32'h100, 32'h800, 4, NO_STOP);
    wait_done("basic");
    for (int k = 0; k < 4; k++) chk("copy_word", mem[512 + k], 32'h1111_1111 * 32'(k + 1));

    // Destination wraps through 0xFFFF_FFFC -> 0.
    launch(32'h100, 32'hFFFF_FFF8, 3, NO_STOP);
    wait_done("wrap");

    // Write-grant stalls of 3, then read-grant stalls of 2.
    wr_stall = 3;
    launch(32'h104, 32'h600, 2, NO_STOP);
    wait_done("wr_stall");
    wr_stall = 0; rd_stall = 2;
    launch(32'h600, 32'h700, 3, NO_STOP);
    wait_done("rd_stall");
    rd_stall = 0;

    // Misaligned source / destination and zero length: no bus traffic.
    r0 = rd_cycles; w0 = wr_cycles;
    launch(32'h102, 32'h800, 4, NO_STOP);
    wait_done("mis_src");
    launch(32'h100, 32'h801, 4, NO_STOP);
    wait_done("mis_dst");
    launch(32'h100, 32'h800, 0, NO_STOP);
    wait_done("len0");
    chk("no_traffic", 32'((rd_cycles - r0) + (wr_cycles - w0)), 32'd0);

    // Read grant never comes: request held TMO cycles, then err=2.
    rd_stall = 100000;
    r0 = rd_cycles;
    launch(32'h100, 32'h800, 2, NO_STOP);
    wait_done("timeout");
    chk("timeout_req_cycles", 32'(rd_cycles - r0), 32'(TMO));
    @(negedge clk);
    chk("timeout_busy_after", 32'(busy), 32'd0);
    rd_stall = 0;

    // Start while busy, then start during the done cycle: both ignored.
    launch(32'h200, 32'hA00, 2, NO_STOP);
    repeat (2) @(posedge clk);
    #1 src_addr = 32'h300; dst_addr = 32'hB00; len_words = 16'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start");
    src_addr = 32'h400; dst_addr = 32'hC00; len_words = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("finish_start_ignored", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);

    // Reset after the second write grant of a four-word copy.
    launch(32'h100, 32'h900, 4, 2);
    nw = 0;
    for (int i = 0; i < 200 && nw < 2; i++) begin
      @(negedge clk);
      if (bus_if.wr_req && bus_if.wr_gnt) nw++;
    end
    chk("reset_test_writes", 32'(nw), 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_reqs", {30'd0, bus_if.rd_req, bus_if.wr_req}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    launch(32'h100, 32'h900, 4, NO_STOP);
    wait_done("after_reset");

    // Randomized aligned copies with random stalls.
    for (int n = 0; n < 12; n++) begin
      rd_stall = $urandom_range(0, 3);
      wr_stall = $urandom_range(0, 3);
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      launch(s, d, $urandom_range(1, 6), NO_STOP);
      wait_done("random");
    end
    rd_stall = 0; wr_stall = 0;
    repeat (5) @(negedge clk);

    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    nw = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nw++;
    chk("ram_image_diffs", 32'(nw), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_dma_copier.md
BUS_DMA_COPIER -- requirements
Module: bus_dma_copier

Interface
REQ-001 The block SHALL have parameter GNT_TIMEOUT, default 255, giving the maximum number of cycles a request may wait for grant before the transfer aborts; legal range 1..65535.
REQ-002 The block SHALL have parameter RD_LATENCY, default 1, giving the cycles from rd_gnt to valid rd_data; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle pulse that launches a copy.
REQ-006 src_addr  input  32  byte address of the first source word.
REQ-007 dst_addr  input  32  byte address of the first destination word.
REQ-008 len_words  input  16  number of 32-bit words to copy.
REQ-009 busy  output  1  high while a copy is in progress.
REQ-010 done  output  1  one-cycle pulse when a copy ends, whether it succeeds or fails.
REQ-011 err  output  2  status valid with done: 0 ok, 1 misaligned, 2 grant timeout.
REQ-012 bus  naive_bus.master  --  initiator port that drives rd_req/rd_addr, wr_req/wr_addr/wr_data/wr_be and samples rd_gnt, rd_data and wr_gnt.

Function
REQ-013 The block SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ and FINISH.
REQ-014 In IDLE, start SHALL latch src_addr, dst_addr and len_words, clear the timeout counter, and move to RD_REQ on the next cycle.
REQ-015 If src_addr[1:0] or dst_addr[1:0] is nonzero at start, the block SHALL go to FINISH with err=1 and issue no bus request.
REQ-016 If len_words is 0 at start, the block SHALL go to FINISH with err=0 and issue no bus request.
REQ-017 In RD_REQ, rd_req SHALL be high with rd_addr equal to the current source address, held stable until the cycle in which rd_gnt is sampled high.
REQ-018 After rd_gnt, the block SHALL wait RD_LATENCY cycles in RD_WAIT and capture rd_data into a 32-bit holding register on the last of them.
REQ-019 In WR_REQ, wr_req SHALL be high with wr_be=4'hF, wr_addr equal to the current destination address, and wr_data equal to the holding register, all held stable until wr_gnt is sampled high.
REQ-020 On wr_gnt, both addresses SHALL increment by 4 and the remaining count SHALL decrement by 1; the block SHALL return to RD_REQ if the count is still nonzero, otherwise go to FINISH with err=0.
REQ-021 Address arithmetic SHALL be 32-bit modulo, so 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
REQ-022 The timeout counter SHALL count the cycles a request is held without grant and SHALL clear on every grant.
REQ-023 When the timeout counter reaches GNT_TIMEOUT, the block SHALL drop the request on the next cycle and go to FINISH with err=2.
REQ-024 FINISH SHALL last exactly one cycle, pulse done, and return to IDLE.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 start while busy SHALL be ignored, and start in the FINISH cycle SHALL also be ignored.
REQ-027 rd_req and wr_req SHALL never be high in the same cycle.
REQ-028 Whenever a request is inactive, its address, data and byte-enable outputs SHALL be 0.
REQ-029 A successful copy of N words with zero-wait grants SHALL take exactly N*(2+RD_LATENCY)+2 cycles from the start cycle to the done cycle, inclusive.

Reset
REQ-030 While rst is sampled high, the block SHALL go to IDLE, and busy, done, err, rd_req, wr_req, all address/data outputs and wr_be SHALL all be 0.
REQ-031 A reset during a copy SHALL abandon it without a done pulse, deasserting any outstanding request at the same edge.
REQ-032 The copy-in-progress and holding registers SHALL also reset to 0.

Structure
REQ-033 The state enum and the err code constants (ERR_OK, ERR_ALIGN, ERR_TIMEOUT) SHALL live in a shared package, dma_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the naive_bus interface SHALL be reused unchanged.

Verification
REQ-035 Attach a zero-wait 4 kB RAM slave, preload 0x100..0x10C with 0x11111111..0x44444444, start with src=0x100, dst=0x800, len=4 -> 0x800..0x80C match the source, done with err=0 exactly 14 cycles after start.
REQ-036 Stall the slave's wr_gnt for 3 cycles on every write with len=2 -> wr_addr and wr_data stay stable during each stall, and done arrives 6 cycles later than with no stall.
REQ-037 Start with src=0x102 -> no rd_req or wr_req ever asserted, done with err=1 two cycles after start.
REQ-038 Tie rd_gnt low with GNT_TIMEOUT=8 -> rd_req held for 8 cycles then dropped, done with err=2, busy low afterwards.
REQ-039 Assert rst for one cycle mid-copy after the second wr_gnt of a len=4 copy -> requests low and busy low at the next edge, no done pulse, and a fresh start afterwards copies correctly.
REQ-040 Start with len=0, and separately pulse start again while busy -> done with err=0 two cycles after start with no bus traffic, and the second start has no effect.
